// File: rtl/interrupt_controller_pkg.sv
// Shared constants and encodings for the interrupt controller and its channels.
// Channel-index width helper keeps the derived ID width consistent everywhere.
package interrupt_controller_pkg;

    localparam int DEF_NUM_CH      = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } mode_e;

    // Channel-index width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_channel.sv
// One interrupt channel: input synchronizer, qualified edge detector,
// pending latch and sticky overrun flag.
module int_channel
    import interrupt_controller_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic int_in,
    input  logic mode,
    input  logic ack_sel,
    output logic pending,
    output logic overrun
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES-1:0] fill_r;
    logic                   prev_r;
    logic                   prev_ok_r;
    mode_e                  mode_r;
    logic                   pending_r;
    logic                   overrun_r;

    mode_e mode_s;
    logic  synced_s;
    logic  rise_s;
    logic  mode_chg_s;
    logic  ack_hit_s;
    logic  pending_nxt_s;
    logic  overrun_nxt_s;

    assign mode_s     = mode_e'(mode);
    assign synced_s   = sync_r[SYNC_STAGES-1];
    // fill_r marks when the chain holds real samples, so a line already high at
    // reset release is seen as a steady level rather than a fresh 0->1.
    assign rise_s     = fill_r[SYNC_STAGES-1] & prev_ok_r & synced_s & ~prev_r;
    assign mode_chg_s = (mode_s != mode_r);
    assign ack_hit_s  = ack_sel & pending_r;

    // Synchronizer, edge history and channel state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r    <= '0;
            fill_r    <= '0;
            prev_r    <= 1'b0;
            prev_ok_r <= 1'b0;
            mode_r    <= mode_s;
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], int_in};
            fill_r    <= {fill_r[SYNC_STAGES-2:0], 1'b1};
            prev_r    <= synced_s;
            prev_ok_r <= fill_r[SYNC_STAGES-1];
            mode_r    <= mode_s;
            pending_r <= pending_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    // Next pending/overrun: mode switch clears, level tracks, edge latches.
    always_comb begin
        pending_nxt_s = pending_r;
        overrun_nxt_s = overrun_r;
        if (mode_chg_s) begin
            pending_nxt_s = 1'b0;
            overrun_nxt_s = 1'b0;
        end else begin
            case (mode_r)
                MODE_LEVEL: begin
                    pending_nxt_s = synced_s;
                    overrun_nxt_s = 1'b0;
                end
                MODE_EDGE: begin
                    if (rise_s) begin
                        pending_nxt_s = 1'b1;
                        if (ack_hit_s) begin
                            overrun_nxt_s = 1'b0;
                        end else if (pending_r) begin
                            overrun_nxt_s = 1'b1;
                        end else begin
                            overrun_nxt_s = overrun_r;
                        end
                    end else if (ack_hit_s) begin
                        pending_nxt_s = 1'b0;
                        overrun_nxt_s = 1'b0;
                    end else begin
                        pending_nxt_s = pending_r;
                        overrun_nxt_s = overrun_r;
                    end
                end
                default: begin
                    pending_nxt_s = 1'b0;
                    overrun_nxt_s = 1'b0;
                end
            endcase
        end
    end

    assign pending = pending_r;
    assign overrun = overrun_r;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller top: NUM_CH channels, lowest-index priority encoder
// and registered irq/irq_id outputs.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int ID_W        = id_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] int_in,
    input  logic [NUM_CH-1:0] mode,
    input  logic [NUM_CH-1:0] mask,
    input  logic              global_en,
    input  logic              ack_valid,
    input  logic [ID_W-1:0]   ack_id,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun
);

    logic [NUM_CH-1:0] pending_s;
    logic [NUM_CH-1:0] overrun_s;
    logic [NUM_CH-1:0] ack_sel_s;
    logic [NUM_CH-1:0] enabled_s;
    logic [ID_W-1:0]   id_s;
    logic              irq_r;
    logic [ID_W-1:0]   irq_id_r;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // An out-of-range ack_id matches no channel and is dropped here.
            assign ack_sel_s[gi] = ack_valid && (ack_id == ID_W'(gi));

            int_channel #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .int_in  (int_in[gi]),
                .mode    (mode[gi]),
                .ack_sel (ack_sel_s[gi]),
                .pending (pending_s[gi]),
                .overrun (overrun_s[gi])
            );
        end
    endgenerate

    assign enabled_s = pending_s & mask;

    // Lowest-index enabled channel; scanning downward lets the lowest win.
    always_comb begin
        id_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            id_s = enabled_s[i] ? ID_W'(i) : id_s;
        end
    end

    // Registered irq and irq_id.
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_r    <= 1'b0;
            irq_id_r <= '0;
        end else begin
            irq_r    <= global_en & (|enabled_s);
            irq_id_r <= id_s;
        end
    end

    assign irq     = irq_r;
    assign irq_id  = irq_id_r;
    assign pending = pending_s;
    assign overrun = overrun_s;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: stimulus queues expected output
// snapshots tagged with an edge number; a monitor compares them at that edge.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] int_in;
    logic [7:0] mode;
    logic [7:0] mask;
    logic       global_en;
    logic       ack_valid;
    logic [2:0] ack_id;
    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] overrun;

    typedef struct {
        int         cyc;
        logic       irq;
        logic [2:0] id;
        logic [7:0] pend;
        logic [7:0] ovr;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    interrupt_controller dut (
        .clk       (clk),
        .rst       (rst),
        .int_in    (int_in),
        .mode      (mode),
        .mask      (mask),
        .global_en (global_en),
        .ack_valid (ack_valid),
        .ack_id    (ack_id),
        .irq       (irq),
        .irq_id    (irq_id),
        .pending   (pending),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect the given output snapshot right after k more rising edges.
    task automatic push_exp(input int k, input logic ei, input logic [2:0] eid,
                            input logic [7:0] ep, input logic [7:0] eo, input string tag);
        exp_t e;
        e.cyc = cyc + k; e.irq = ei; e.id = eid; e.pend = ep; e.ovr = eo; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        checks++;
        if (irq !== e.irq || irq_id !== e.id || pending !== e.pend || overrun !== e.ovr) begin
            errors++;
            $display("FAIL %s edge %0d: irq/id/pend/ovr got %b/%0d/%h/%h want %b/%0d/%h/%h",
                     e.tag, cyc, irq, irq_id, pending, overrun, e.irq, e.id, e.pend, e.ovr);
        end
    endtask

    // Monitor: after each rising edge, check every expectation due now.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc) begin
                    compare(q[i]);
                    q.delete(i);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b0; int_in = 8'h00; mode = 8'hFE; mask = 8'hFF;
        global_en = 1'b1; ack_valid = 1'b0; ack_id = 3'd0;

        // Reset state.
        step(1);
        push_exp(1, 1'b0, 3'd0, 8'h00, 8'h00, "reset");
        step(2);
        rst = 1'b1;
        step(6);

        // Edge latency on ch3, hold until ack, drop two edges after ack.
        int_in[3] = 1'b1;
        push_exp(3, 1'b0, 3'd0, 8'h08, 8'h00, "t1_pend");
        push_exp(4, 1'b1, 3'd3, 8'h08, 8'h00, "t1_irq");
        push_exp(8, 1'b1, 3'd3, 8'h08, 8'h00, "t1_hold");
        step(1); int_in[3] = 1'b0;
        step(9);
        ack_valid = 1'b1; ack_id = 3'd3;
        push_exp(1, 1'b1, 3'd3, 8'h00, 8'h00, "t1_ack1");
        push_exp(2, 1'b0, 3'd0, 8'h00, 8'h00, "t1_ack2");
        step(1); ack_valid = 1'b0;
        step(4);

        // Priority: ch5 and ch2 together, lowest wins, then ack in turn.
        int_in[5] = 1'b1; int_in[2] = 1'b1;
        push_exp(4, 1'b1, 3'd2, 8'h24, 8'h00, "t2_prio");
        step(1); int_in[5] = 1'b0; int_in[2] = 1'b0;
        step(5);
        ack_valid = 1'b1; ack_id = 3'd2;
        push_exp(1, 1'b1, 3'd2, 8'h20, 8'h00, "t2_ack2");
        step(1); ack_id = 3'd5;
        push_exp(1, 1'b1, 3'd5, 8'h00, 8'h00, "t2_ack5a");
        push_exp(2, 1'b0, 3'd0, 8'h00, 8'h00, "t2_ack5b");
        step(1); ack_valid = 1'b0;
        step(4);

        // Overrun: second ch1 edge six cycles later without ack.
        int_in[1] = 1'b1;
        push_exp(4, 1'b1, 3'd1, 8'h02, 8'h00, "t3_first");
        step(1); int_in[1] = 1'b0;
        step(5); int_in[1] = 1'b1;
        push_exp(2, 1'b1, 3'd1, 8'h02, 8'h00, "t3_preovr");
        push_exp(3, 1'b1, 3'd1, 8'h02, 8'h02, "t3_ovr");
        step(1); int_in[1] = 1'b0;
        step(4);
        ack_valid = 1'b1; ack_id = 3'd1;
        push_exp(1, 1'b1, 3'd1, 8'h00, 8'h00, "t3_ackclr");
        push_exp(2, 1'b0, 3'd0, 8'h00, 8'h00, "t3_irqlow");
        step(1); ack_valid = 1'b0;
        step(4);

        // New edge coinciding with ack: set wins; ack of idle channel ignored.
        int_in[4] = 1'b1;
        step(1); int_in[4] = 1'b0;
        step(5); int_in[4] = 1'b1;
        step(1); int_in[4] = 1'b0;
        step(1);
        ack_valid = 1'b1; ack_id = 3'd4;
        push_exp(1, 1'b1, 3'd4, 8'h10, 8'h00, "t4_setwins");
        step(1); ack_id = 3'd6;
        push_exp(1, 1'b1, 3'd4, 8'h10, 8'h00, "t4_idleack");
        step(1); ack_id = 3'd4;
        push_exp(2, 1'b0, 3'd0, 8'h00, 8'h00, "t4_clear");
        step(1); ack_valid = 1'b0;
        step(4);

        // Level mode ch0 with mask, ack has no effect.
        mask[0] = 1'b0;
        step(1);
        int_in[0] = 1'b1;
        push_exp(4, 1'b0, 3'd0, 8'h01, 8'h00, "t5_masked");
        step(5); mask[0] = 1'b1;
        push_exp(1, 1'b1, 3'd0, 8'h01, 8'h00, "t5_unmask");
        step(2); ack_valid = 1'b1; ack_id = 3'd0;
        push_exp(1, 1'b1, 3'd0, 8'h01, 8'h00, "t5_ackign");
        step(1); ack_valid = 1'b0; int_in[0] = 1'b0;
        push_exp(3, 1'b1, 3'd0, 8'h00, 8'h00, "t5_fall3");
        push_exp(4, 1'b0, 3'd0, 8'h00, 8'h00, "t5_fall4");
        step(6);

        // ch7 pending, global_en gating, reset with line held high.
        int_in[7] = 1'b1;
        push_exp(4, 1'b1, 3'd7, 8'h80, 8'h00, "t6_irq");
        step(4); global_en = 1'b0;
        push_exp(1, 1'b0, 3'd7, 8'h80, 8'h00, "t6_gen0");
        step(1); global_en = 1'b1;
        push_exp(1, 1'b1, 3'd7, 8'h80, 8'h00, "t6_gen1");
        step(1); rst = 1'b0;
        push_exp(1, 1'b0, 3'd0, 8'h00, 8'h00, "t6_rst");
        step(1); rst = 1'b1;
        push_exp(8, 1'b0, 3'd0, 8'h00, 8'h00, "t6_norearm");
        step(10); int_in[7] = 1'b0;
        step(3); int_in[7] = 1'b1;
        push_exp(3, 1'b0, 3'd0, 8'h80, 8'h00, "t6_repend");
        push_exp(4, 1'b1, 3'd7, 8'h80, 8'h00, "t6_reirq");
        step(5);

        // Switching ch7 to level clears it, then it follows the high line.
        mode[7] = 1'b0;
        push_exp(1, 1'b1, 3'd7, 8'h00, 8'h00, "t7_modeclr");
        push_exp(2, 1'b0, 3'd0, 8'h80, 8'h00, "t7_level");
        push_exp(3, 1'b1, 3'd7, 8'h80, 8'h00, "t7_levirq");

        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            step(1);
            guard++;
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never checked: due edge %0d, now %0d", e.tag, e.cyc, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
